imem_access_controller: RTL and testbench
=========================================

Name: imem_access_controller

Overview:
Owns the single access port of the 64x32 instruction memory and sequences all traffic to it. After reset it zero-clears the array, then accepts a program image from a loader, then serves fetch-stage reads. In RUN it arbitrates between fetch reads and late loader writes using fetch priority with a starvation guard. It sits between the fetch stage, the program loader and the instruction-memory array.

Parameters:
DEPTH, 64, number of 32-bit instruction words
ADDR_W, 6, word-index width; must equal log2(DEPTH)
STARVE_MAX, 4, consecutive denied loader cycles in RUN before the loader is forced a slot (range 1..15)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
fetch_req  in  1  fetch stage requests an instruction
fetch_pc  in  32  fetch byte address
fetch_gnt  out  1  request accepted this cycle (combinational)
fetch_rvalid  out  1  registered; instruction or error is valid
fetch_rdata  out  32  registered instruction word
fetch_err  out  1  registered; misaligned or out-of-range pc
ld_valid  in  1  loader write request
ld_addr  in  ADDR_W  loader word index
ld_data  in  32  loader write data
ld_ready  out  1  loader write accepted this cycle (combinational)
ld_done  in  1  loader signals the image is complete
reload_req  in  1  return from RUN to LOAD
mem_en  out  1  array access strobe
mem_we  out  1  array write enable
mem_addr  out  ADDR_W  array word index
mem_wdata  out  32  array write data
mem_rdata  in  32  array read data, combinational from mem_addr
state  out  2  0=CLEAR, 1=LOAD, 2=RUN
busy  out  1  high when state != RUN

Behaviour:
- Reset (rst=1 at a rising edge): state=CLEAR, clear pointer=0, starve_cnt=0, fetch_rvalid=0, fetch_err=0, fetch_rdata=0. rst overrides every other input, including mid-clear, mid-load and during an in-flight read.
- CLEAR: each cycle drives mem_en=1, mem_we=1, mem_addr=pointer, mem_wdata=0, then increments pointer. After the write to DEPTH-1 the next state is LOAD. This takes exactly DEPTH cycles. ld_ready=0 and fetch_gnt=0 throughout.
- LOAD: ld_ready=1. ld_valid causes a write of ld_data to ld_addr in the same cycle. fetch_gnt=0. ld_done moves the state to RUN on the next cycle. If ld_done and ld_valid are both high, the write is still performed.
- RUN, fetch index: idx = fetch_pc[ADDR_W+1:2]. A request is bad if fetch_pc[1:0] != 0 or fetch_pc >= 4*DEPTH.
- RUN, forced loader slot: if ld_valid=1 and starve_cnt >= STARVE_MAX, the loader is granted (ld_ready=1, write), fetch_gnt=0, and starve_cnt is reset to 0.
- RUN, fetch priority: otherwise, if fetch_req=1, then fetch_gnt=1.
  - Good request: mem_en=1, mem_we=0, mem_addr=idx. Next cycle fetch_rvalid=1 and fetch_rdata=the mem_rdata sampled at grant.
  - Bad request: no array access. Next cycle fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
  - Read latency is 1 cycle. fetch_rvalid is a single-cycle pulse per grant, and back-to-back grants give back-to-back pulses.
- RUN, loader only: otherwise, if ld_valid=1, the loader is granted.
- RUN, starvation counter: starve_cnt increments (saturating at 15) on every cycle in which ld_valid=1 and ld_ready=0. It resets on a loader grant or when ld_valid=0.
- RUN, reload: reload_req moves the state to LOAD next cycle, and that cycle's grants still complete. ld_done outside LOAD is ignored.
- mem_en=0 in any cycle with no grant. mem_wdata=ld_data whenever a loader write occurs.
- state, busy, fetch_rvalid, fetch_rdata and fetch_err are registered. fetch_gnt, ld_ready and all mem_* outputs are combinational from state and inputs.

Test Plan:
- Reset then idle: rst for 1 cycle -> 64 cycles of mem_we=1, mem_wdata=0, addr 0..63. busy=1 throughout, then state=1 at cycle 65.
- Load then fetch: write 0x00500093 to index 3, pulse ld_done, then fetch_pc=0x0C -> fetch_gnt=1. Next cycle fetch_rvalid=1, fetch_rdata=0x00500093, fetch_err=0.
- Bad pc: fetch_pc=0x0E, then fetch_pc=0x100 -> each gives fetch_gnt=1, mem_en=0, and next cycle fetch_rvalid=1, fetch_err=1, rdata=0.
- Starvation (STARVE_MAX=4): fetch_req and ld_valid held high in RUN -> 4 fetch grants, then 1 loader write with fetch_gnt=0, then the pattern repeats.
- Reset mid-clear at cycle 20 and mid-load -> state returns to CLEAR, pointer restarts at 0, full 64-cycle clear, no stale fetch_rvalid.
- reload_req in RUN with fetch_req high -> fetch_gnt=0 from the next cycle, ld_ready=1, state=1.

Source files
------------

// File: rtl/imem_access_controller.sv
// Sole owner of the 64x32 instruction-memory port: clears the array, takes a loader image,
// then serves fetch reads, with fetch priority and a starvation guard for late loader writes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero-fill the array, one word per cycle, pointer 0..DEPTH-1
// ST_LOAD  | loader owns the port; ld_done moves to RUN
// ST_RUN   | fetch reads with priority; loader forced in after STARVE_MAX denials
module imem_access_controller #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_err,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  input  logic              reload_req,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        state,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [3:0]        starve_cnt_q;
  logic              busy_q;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] fetch_idx;
  logic              pc_bad;
  logic              ld_gnt;

  assign fetch_idx = fetch_pc[ADDR_W+1:2];
  assign pc_bad    = (fetch_pc[1:0] != 2'b00) || (fetch_pc >= 32'(4 * DEPTH));

  always_comb begin
    state_d   = state_q;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    ld_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_ptr_q;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        ld_gnt   = ld_valid;
        if (ld_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ld_valid && (starve_cnt_q >= 4'(STARVE_MAX))) begin
          ld_gnt = 1'b1;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
          // Bad addresses are answered with an error and never touch the array.
          if (!pc_bad) begin
            mem_en   = 1'b1;
            mem_addr = fetch_idx;
          end
        end else if (ld_valid) begin
          ld_gnt = 1'b1;
        end
        ld_ready = ld_gnt;
        if (reload_req) state_d = ST_LOAD;
      end
      default: state_d = ST_CLEAR;
    endcase
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      starve_cnt_q <= '0;
      busy_q       <= 1'b1;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != ST_RUN);
      rvalid_q <= fetch_gnt;
      err_q    <= fetch_gnt && pc_bad;
      if (fetch_gnt) rdata_q <= pc_bad ? 32'h0 : mem_rdata;
      if (state_q == ST_CLEAR) clr_ptr_q <= clr_ptr_q + 1'b1;
      if ((state_q == ST_RUN) && ld_valid && !ld_ready) begin
        if (starve_cnt_q != 4'hF) starve_cnt_q <= starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end

  assign state        = state_q;
  assign busy         = busy_q;
  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign fetch_rdata  = rdata_q;

endmodule

// File: tb/tb_imem_access_controller.sv
// Directed bench for imem_access_controller: clear sweep, load, fetch, bad pc,
// starvation arbitration, reload and reset-in-the-middle scenarios.
module tb_imem_access_controller;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        reload_req;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  state;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic        tb_fill;
  logic [31:0] bmem [64];

  imem_access_controller #(.DEPTH(64), .ADDR_W(6), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .reload_req(reload_req),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state(state), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction array: garbage-filled on demand so the clear sweep is observable.
  assign mem_rdata = bmem[mem_addr];
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 64; i++) bmem[i] <= 32'hDEAD_0000 | i;
    end else if (mem_en && mem_we) begin
      bmem[mem_addr] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_fill = 1'b1;
    step();
    rst = 1'b0; tb_fill = 1'b0;
    tests++;
    if (state !== 2'd0 || busy !== 1'b1 || fetch_rvalid !== 1'b0 ||
        fetch_err !== 1'b0 || fetch_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got state=%0d busy=%b rvalid=%b err=%b rdata=%h, expected 0 1 0 0 00000000",
               state, busy, fetch_rvalid, fetch_err, fetch_rdata);
    end
  endtask

  task automatic test_clear();
    int bad_words;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) begin
      #1;
      tests++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== 32'h0 ||
          ld_ready !== 1'b0 || fetch_gnt !== 1'b0 || busy !== 1'b1 || state !== 2'd0) begin
        fails++;
        $display("FAIL clear_cycle %0d: got en=%b we=%b addr=%0d wdata=%h ld_ready=%b gnt=%b busy=%b state=%0d, expected 1 1 %0d 0 0 0 1 0",
                 i, mem_en, mem_we, mem_addr, mem_wdata, ld_ready, fetch_gnt, busy, state, i);
      end
      @(posedge clk);
      #1;
    end
    fetch_req = 1'b0; ld_valid = 1'b0;
    tests++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_to_load: got state=%0d busy=%b, expected state=1 busy=1", state, busy);
    end
    bad_words = 0;
    for (int i = 0; i < 64; i++) if (bmem[i] !== 32'h0) bad_words++;
    tests++;
    if (bad_words != 0) begin
      fails++;
      $display("FAIL clear_contents: got %0d nonzero words, expected 0", bad_words);
    end
  endtask

  task automatic test_load_fetch();
    ld_valid = 1'b1; ld_addr = 6'd3; ld_data = 32'h0050_0093;
    fetch_req = 1'b1; fetch_pc = 32'h0C;
    #1;
    tests++;
    if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd3 ||
        mem_wdata !== 32'h0050_0093 || fetch_gnt !== 1'b0) begin
      fails++;
      $display("FAIL load_write: got ld_ready=%b en=%b we=%b addr=%0d wdata=%h gnt=%b, expected 1 1 1 3 00500093 0",
               ld_ready, mem_en, mem_we, mem_addr, mem_wdata, fetch_gnt);
    end
    step();
    ld_addr = 6'd5; ld_data = 32'h1234_5678; ld_done = 1'b1;
    #1;
    tests++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd5) begin
      fails++;
      $display("FAIL load_with_done: got ld_ready=%b we=%b addr=%0d, expected 1 1 5", ld_ready, mem_we, mem_addr);
    end
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    tests++;
    if (state !== 2'd2 || busy !== 1'b0 || fetch_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL enter_run: got state=%0d busy=%b rvalid=%b, expected 2 0 0", state, busy, fetch_rvalid);
    end
    #1;
    tests++;
    if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd3) begin
      fails++;
      $display("FAIL fetch_grant: got gnt=%b en=%b we=%b addr=%0d, expected 1 1 0 3", fetch_gnt, mem_en, mem_we, mem_addr);
    end
    step();
    tests++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h0050_0093 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL fetch_data: got rvalid=%b rdata=%h err=%b, expected 1 00500093 0", fetch_rvalid, fetch_rdata, fetch_err);
    end
    fetch_pc = 32'h14;
    #1;
    tests++;
    if (fetch_gnt !== 1'b1 || mem_addr !== 6'd5) begin
      fails++;
      $display("FAIL b2b_grant: got gnt=%b addr=%0d, expected 1 5", fetch_gnt, mem_addr);
    end
    step();
    fetch_req = 1'b0;
    tests++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h1234_5678 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_data: got rvalid=%b rdata=%h err=%b, expected 1 12345678 0", fetch_rvalid, fetch_rdata, fetch_err);
    end
    step();
    tests++;
    if (fetch_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rvalid_pulse: got rvalid=%b, expected 0", fetch_rvalid);
    end
  endtask

  task automatic test_bad_pc();
    logic [31:0] pcs [3];
    logic        exp_err [3];
    pcs = '{32'h0E, 32'h100, 32'hFC};
    exp_err = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      fetch_req = 1'b1; fetch_pc = pcs[k];
      #1;
      tests++;
      if (fetch_gnt !== 1'b1 || mem_en !== !exp_err[k]) begin
        fails++;
        $display("FAIL bad_pc_grant pc=%h: got gnt=%b en=%b, expected 1 %b", pcs[k], fetch_gnt, mem_en, !exp_err[k]);
      end
      step();
      tests++;
      if (fetch_rvalid !== 1'b1 || fetch_err !== exp_err[k] || fetch_rdata !== 32'h0) begin
        fails++;
        $display("FAIL bad_pc_resp pc=%h: got rvalid=%b err=%b rdata=%h, expected 1 %b 00000000",
                 pcs[k], fetch_rvalid, fetch_err, fetch_rdata, exp_err[k]);
      end
    end
    fetch_req = 1'b0;
    step();
    tests++;
    if (fetch_rvalid !== 1'b0 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL bad_pc_idle: got rvalid=%b err=%b, expected 0 0", fetch_rvalid, fetch_err);
    end
  endtask

  task automatic test_starvation();
    logic freq_v [15];
    logic ldv_v  [15];
    logic ld_v   [15];
    logic exp_fg;
    logic prev_fg;
    freq_v = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    ldv_v  = '{1,1,1,1,1,1,1,0,1,1,1,1,1,0,1};
    ld_v   = '{0,0,0,0,1,0,0,0,0,0,0,0,1,0,1};
    prev_fg = 1'b0;
    fetch_pc = 32'h0C; ld_addr = 6'd10;
    for (int c = 0; c < 15; c++) begin
      fetch_req = freq_v[c]; ld_valid = ldv_v[c]; ld_data = 32'hA5A5_0000 + c;
      exp_fg = freq_v[c] && !ld_v[c];
      #1;
      tests++;
      if (fetch_gnt !== exp_fg || ld_ready !== ld_v[c] || mem_we !== ld_v[c] || fetch_rvalid !== prev_fg) begin
        fails++;
        $display("FAIL starve_cycle %0d: got gnt=%b ld_ready=%b we=%b rvalid=%b, expected %b %b %b %b",
                 c, fetch_gnt, ld_ready, mem_we, fetch_rvalid, exp_fg, ld_v[c], ld_v[c], prev_fg);
      end
      prev_fg = exp_fg;
      step();
    end
    fetch_req = 1'b0; ld_valid = 1'b0;
    tests++;
    if (bmem[10] !== 32'hA5A5_000E || fetch_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL starve_write: got mem[10]=%h rvalid=%b, expected a5a5000e 0", bmem[10], fetch_rvalid);
    end
  endtask

  task automatic test_reload();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    tests++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL done_ignored_in_run: got state=%0d, expected 2", state);
    end
    fetch_req = 1'b1; fetch_pc = 32'h0C; reload_req = 1'b1;
    #1;
    tests++;
    if (fetch_gnt !== 1'b1) begin
      fails++;
      $display("FAIL reload_grant: got gnt=%b, expected 1", fetch_gnt);
    end
    step();
    reload_req = 1'b0;
    #1;
    tests++;
    if (state !== 2'd1 || busy !== 1'b1 || fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h0050_0093 ||
        fetch_gnt !== 1'b0 || ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL reload_load: got state=%0d busy=%b rvalid=%b rdata=%h gnt=%b ld_ready=%b, expected 1 1 1 00500093 0 1",
               state, busy, fetch_rvalid, fetch_rdata, fetch_gnt, ld_ready);
    end
    fetch_req = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_pc = 32'h14; rst = 1'b1; tb_fill = 1'b1;
    step();
    rst = 1'b0; tb_fill = 1'b0; fetch_req = 1'b0;
    tests++;
    if (state !== 2'd0 || fetch_rvalid !== 1'b0 || busy !== 1'b1 || fetch_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_in_run: got state=%0d rvalid=%b busy=%b rdata=%h, expected 0 0 1 00000000",
               state, fetch_rvalid, busy, fetch_rdata);
    end
    for (int i = 0; i < 20; i++) step();
    tests++;
    if (mem_addr !== 6'd20 || state !== 2'd0) begin
      fails++;
      $display("FAIL mid_clear_ptr: got addr=%0d state=%0d, expected 20 0", mem_addr, state);
    end
    rst = 1'b1; tb_fill = 1'b1;
    step();
    rst = 1'b0; tb_fill = 1'b0;
    test_clear();
    rst = 1'b1; tb_fill = 1'b1;
    step();
    rst = 1'b0; tb_fill = 1'b0;
    tests++;
    if (state !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_load: got state=%0d busy=%b, expected 0 1", state, busy);
    end
    test_clear();
  endtask

  initial begin
    rst = 1'b0; tb_fill = 1'b0;
    fetch_req = 1'b0; fetch_pc = 32'h0;
    ld_valid = 1'b0; ld_addr = 6'd0; ld_data = 32'h0;
    ld_done = 1'b0; reload_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_clear();
    test_load_fetch();
    test_bad_pc();
    test_starvation();
    test_reload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
